// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
package ctrl_pkg;

    // Stage indices of the fixed front end; the last stage is WB.
    localparam int IF = 0;
    localparam int ID = 1;
    localparam int EX = 2;

    // Stored register tags are zero-extended to this width so the record
    // type can stay parameter-free; REG_ADDR_W must not exceed it.
    localparam int REG_RD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic                valid;
        logic [REG_RD_W-1:0] rd;
        logic                wr_en;
        logic                is_load;
    } stage_rec_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - ID/EX attributes in, per-stage status and stall/flush controls out
interface pipe_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5
);
    logic                  if_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_wr_en;
    logic                  id_is_load;
    logic                  ex_redirect;
    logic [NUM_STAGES-1:0] stage_valid;
    logic                  stall_if;
    logic                  stall_id;
    logic                  bubble_ex;
    logic                  flush;

    // Core side: supplies instruction attributes, obeys the controls.
    modport master (
        output if_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wr_en, id_is_load, ex_redirect,
        input  stage_valid, stall_if, stall_id, bubble_ex, flush
    );

    // Controller side.
    modport slave (
        input  if_valid, id_rs, id_rt, id_rs_used, id_rt_used,
               id_rd, id_wr_en, id_is_load, ex_redirect,
        output stage_valid, stall_if, stall_id, bubble_ex, flush
    );
endinterface

// File: rtl/pipe_ctrl_hazard_chk.sv
// rtl/pipe_ctrl_hazard_chk.sv - load-use comparison of ID sources against the load shadow window
module hazard_chk
    import ctrl_pkg::*;
#(
    parameter int LOAD_LAT   = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  stage_rec_t            win [LOAD_LAT],
    output logic                  haz
);

    // Any in-flight load whose data is not yet forwardable and whose
    // nonzero destination feeds a used ID source forces a stall.
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (id_valid && win[i].valid && win[i].is_load && win[i].wr_en &&
                (win[i].rd != '0)) begin
                if ((id_rs_used && (win[i].rd == REG_RD_W'(id_rs))) ||
                    (id_rt_used && (win[i].rd == REG_RD_W'(id_rt)))) begin
                    haz = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing, load-use stall and redirect squash controller
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             opr_finished,
    pipe_ctrl_if.slave       pif,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]            state;
    logic                  v_if;
    logic                  v_id;
    stage_rec_t            rec [EX:NUM_STAGES-1];
    stage_rec_t            win [LOAD_LAT];
    stage_rec_t            ex_next;
    logic [NUM_STAGES-1:0] sv;
    logic                  haz;
    logic                  redirect;
    logic                  haz_eff;
    logic                  fetch_en;

    // Stages EX..EX+LOAD_LAT-1 hold loads whose data is not yet forwardable.
    always_comb begin
        for (int i = 0; i < LOAD_LAT; i++) begin
            win[i] = rec[EX+i];
        end
    end

    hazard_chk #(
        .LOAD_LAT   (LOAD_LAT),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_chk (
        .id_valid   (v_id),
        .id_rs      (pif.id_rs),
        .id_rt      (pif.id_rt),
        .id_rs_used (pif.id_rs_used),
        .id_rt_used (pif.id_rt_used),
        .win        (win),
        .haz        (haz)
    );

    // A redirect squashes the ID instruction, so a stall for it is pointless.
    assign redirect = pif.ex_redirect & rec[EX].valid;
    assign haz_eff  = haz & ~redirect;
    assign fetch_en = (state == S_RUN) & ~opr_finished;

    assign pif.stall_if  = haz_eff;
    assign pif.stall_id  = haz_eff;
    assign pif.bubble_ex = haz_eff;
    assign pif.flush     = redirect;

    // Gather per-stage valid bits into one vector.
    always_comb begin
        sv     = '0;
        sv[IF] = v_if;
        sv[ID] = v_id;
        for (int k = EX; k < NUM_STAGES; k++) begin
            sv[k] = rec[k].valid;
        end
    end

    assign pif.stage_valid = sv;

    // Record entering EX: the ID instruction, or a bubble on stall/squash.
    always_comb begin
        ex_next = '0;
        if (!(redirect || haz_eff)) begin
            ex_next.valid   = v_id;
            ex_next.rd      = REG_RD_W'(pif.id_rd);
            ex_next.wr_en   = pif.id_wr_en;
            ex_next.is_load = pif.id_is_load;
        end
    end

    // Advance the pipeline: IF/ID hold on stall, clear on redirect; EX onward always shifts.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            v_if <= 1'b0;
            v_id <= 1'b0;
            for (int k = EX; k < NUM_STAGES; k++) begin
                rec[k] <= '0;
            end
        end else begin
            if (redirect) begin
                v_if <= 1'b0;
                v_id <= 1'b0;
            end else if (!haz_eff) begin
                v_if <= fetch_en & pif.if_valid;
                v_id <= v_if;
            end
            rec[EX] <= ex_next;
            for (int k = EX + 1; k < NUM_STAGES; k++) begin
                rec[k] <= rec[k-1];
            end
        end
    end

    // Operation sequencing: start, drain until empty, one DONE cycle.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (opr_finished) state <= S_DRAIN;
                S_DRAIN: if (sv == '0) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // Saturating retire and stall counters.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            retired   <= '0;
            stall_cnt <= '0;
        end else begin
            if (rec[NUM_STAGES-1].valid && (retired != '1)) begin
                retired <= retired + CNT_W'(1);
            end
            if (haz_eff && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline sequencing and hazard controller for the in-order MIPS-style core. It generalises the fixed five-stage operation control to `NUM_STAGES` stages. It tracks a valid bit and destination-register tag per stage, detects load-use hazards with a configurable load latency, and squashes younger stages on an EX-stage redirect. It runs a start/drain/done sequence with retire and stall counters, and sits beside `inst_f`, `id`, `mem` and `wb`, driving their stall and flush controls.

## Interface
Parameters:
- `NUM_STAGES`, 5: pipeline depth, 4 to 8. Stage 0 = IF, 1 = ID, 2 = EX, the last stage = WB.
- `REG_ADDR_W`, 5: register-address width.
- `LOAD_LAT`, 1: cycles after EX before load data can be forwarded, 1 to `NUM_STAGES`-3.
- `CNT_W`, 32: counter width.

Ports:
- `clk` in 1: the only clock.
- `rstb` in 1: asynchronous, active-low reset.
- `start` in 1: begin operation from IDLE.
- `opr_finished` in 1: stop fetching and drain the pipeline.
- `if_valid` in 1: fetch holds a valid instruction.
- `id_rs`, `id_rt` in `REG_ADDR_W`: source registers of the ID instruction.
- `id_rs_used`, `id_rt_used` in 1: the corresponding source is actually read.
- `id_rd` in `REG_ADDR_W`, `id_wr_en` in 1, `id_is_load` in 1: ID instruction's destination attributes.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `stage_valid` out `NUM_STAGES`: per-stage valid bits.
- `stall_if`, `stall_id` out 1: hold the PC and the IF/ID register.
- `bubble_ex` out 1: EX receives a bubble this cycle.
- `flush` out 1: squash IF and ID.
- `busy`, `done` out 1: status; `done` is a one-cycle pulse.
- `retired`, `stall_cnt` out `CNT_W`: saturating counters.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DRAIN on `opr_finished`.
  - DRAIN to DONE when `stage_valid` is all zero.
  - DONE to IDLE unconditionally.
  - `start` outside IDLE is ignored.
- Fetch entry:
  - In RUN, stage 0 valid takes `if_valid` when not stalled.
  - In DRAIN, IDLE and DONE, stage 0 valid takes 0.
- Per-stage record for stages 2 and later: valid, rd, wr_en, is_load.
  - Each record shifts one stage per cycle.
  - The ID-to-EX move captures the `id_*` inputs.
- Load-use hazard, `haz`, is asserted when all of the following hold:
  - stage 1 is valid;
  - some stage k in 2 to 1+`LOAD_LAT` is valid with is_load=1, wr_en=1 and rd≠0;
  - that rd equals `id_rs` with `id_rs_used`=1, or equals `id_rt` with `id_rt_used`=1.
- Register 0 never causes a hazard.
- On `haz`:
  - `stall_if`=`stall_id`=1 and `bubble_ex`=1.
  - Stages 0 and 1 hold.
  - Stage 2 is loaded invalid; stages 2 and later keep shifting.
- Redirect: `ex_redirect` with stage 2 valid gives `flush`=1.
  - Stages 0 and 1 are cleared at the next edge.
  - The EX instruction proceeds.
  - Redirect overrides `haz`: no stall that cycle.
  - `ex_redirect` with stage 2 invalid is ignored.
- Counters:
  - `retired` increments while the last stage is valid.
  - `stall_cnt` increments on each `haz` cycle.
  - Both saturate at all-ones and clear only on reset.
- `busy` = state is RUN or DRAIN.

## Timing
- Reset values: state IDLE; every output 0, including `stage_valid`, counters, `done` and `busy`.
- Reset asserted mid-operation clears everything immediately (asynchronous); no drain occurs.
- `stall_if`, `stall_id`, `bubble_ex` and `flush` are combinational from the current registers and inputs, within the same cycle.
- Latency:
  - An instruction entering IF at edge t reaches the last stage at edge t+`NUM_STAGES`-1, plus one cycle per `haz` cycle.
  - Squashed instructions never reach the last stage.
- Load-use stall length: exactly `LOAD_LAT` - (k-2) cycles for a load at stage k. With the default `LOAD_LAT`=1 it is 1 cycle.
- `opr_finished` and `ex_redirect` in the same cycle: both take effect.
- `done` pulses one cycle after `stage_valid` reaches all zero in DRAIN.
- `opr_finished` in DRAIN or IDLE: no effect.

## Structure
- `ctrl_pkg`: FSM state enum, the `stage_rec_t` struct (valid, rd, wr_en, is_load), and stage-index constants IF=0, ID=1, EX=2.
- Sub-module `hazard_chk`: purely combinational comparison of the ID sources against stages 2 to 1+`LOAD_LAT`. It is instantiated once.

## Test plan
- Reset, then `start` and `if_valid`=1 for 3 cycles: `stage_valid` walks 00001, 00011, 00111, ...; `retired`=3 after the last one drains.
- Load to r5 in EX while ID reads r5 (`id_rs_used`=1): `stall_if`=`stall_id`=`bubble_ex`=1 for 1 cycle; `stall_cnt`=1. With `LOAD_LAT`=2, the stall lasts 2 cycles.
- Load to r0 in EX, ID reads r0: no stall. Load to r5 with ID `id_rs_used`=0: no stall.
- Hazard and `ex_redirect` in the same cycle: `flush`=1 and no stall; stages 0 and 1 are invalid next cycle; the branch retires and the squashed instructions do not (`retired` counts only the branch).
- `opr_finished` with 4 instructions in flight: no new entries; `done` pulses once after the 4 retire, then the state is IDLE; `rstb` asserted mid-drain zeroes all outputs immediately.
